// File: rtl/phase_sequencer.sv
// One-hot instruction phase generator with early end, stall hold, cycle counter.
// Optional single-step debug ports are built when PHASE_SEQ_STEP_EN is defined.
module phase_sequencer #(
   parameter  int NUM_PHASES = 7,
   parameter  int CNT_W      = 16,
   localparam int IDX_W      = $clog2(NUM_PHASES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alive,
   input  logic                  stall,
   input  logic                  end_early,
`ifdef PHASE_SEQ_STEP_EN
   input  logic                  step_mode,
   input  logic                  step,
`endif
   output logic [NUM_PHASES-1:0] phase,
   output logic [IDX_W-1:0]      phase_idx,
   output logic                  cycle_done,
   output logic [CNT_W-1:0]      cycle_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

   logic                  hold;
   logic [IDX_W-1:0]      idx_next;
   logic [NUM_PHASES-1:0] phase_next;
   logic [CNT_W-1:0]      cnt_next;
   logic                  done_next;

`ifdef PHASE_SEQ_STEP_EN
   assign hold = stall | (step_mode & ~step);
`else
   assign hold = stall;
`endif

   // A drop of alive is a forced return, not a wrap: no pulse, no count.
   always_comb begin
      idx_next  = phase_idx;
      cnt_next  = cycle_count;
      done_next = 1'b0;
      if (!alive) begin
         idx_next = '0;
      end else if (!hold) begin
         if (end_early || (phase_idx == LAST_IDX)) begin
            idx_next  = '0;
            cnt_next  = cycle_count + CNT_W'(1);
            done_next = 1'b1;
         end else begin
            idx_next = phase_idx + IDX_W'(1);
         end
      end
      phase_next = NUM_PHASES'(1) << idx_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_idx   <= '0;
         phase       <= NUM_PHASES'(1);
         cycle_done  <= 1'b0;
         cycle_count <= '0;
      end else begin
         phase_idx   <= idx_next;
         phase       <= phase_next;
         cycle_done  <= done_next;
         cycle_count <= cnt_next;
      end
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a 7-phase/16-bit instance plus a
// 2-phase/3-bit instance for the counter wrap; step mode under PHASE_SEQ_STEP_EN.
module tb_phase_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, alive, stall, end_early;
   logic        step_mode, step;
   logic [6:0]  phase;
   logic [2:0]  phase_idx;
   logic        cycle_done;
   logic [15:0] cycle_count;
   logic [1:0]  phase2;
   logic [0:0]  phase_idx2;
   logic        cycle_done2;
   logic [2:0]  cycle_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   phase_sequencer #(.NUM_PHASES(7), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .alive(alive), .stall(stall), .end_early(end_early),
`ifdef PHASE_SEQ_STEP_EN
      .step_mode(step_mode), .step(step),
`endif
      .phase(phase), .phase_idx(phase_idx), .cycle_done(cycle_done),
      .cycle_count(cycle_count)
   );

   phase_sequencer #(.NUM_PHASES(2), .CNT_W(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .alive(alive), .stall(1'b0), .end_early(1'b0),
`ifdef PHASE_SEQ_STEP_EN
      .step_mode(1'b0), .step(1'b0),
`endif
      .phase(phase2), .phase_idx(phase_idx2), .cycle_done(cycle_done2),
      .cycle_count(cycle_count2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk7(input string tag, input int eidx, input int edone, input int ecnt);
      chk({tag, "_idx"},   32'(phase_idx),   32'(eidx));
      chk({tag, "_phase"}, 32'(phase),       32'(1) << eidx);
      chk({tag, "_done"},  32'(cycle_done),  32'(edone));
      chk({tag, "_cnt"},   32'(cycle_count), 32'(ecnt));
   endtask

   initial begin
      rst_n = 1'b0; alive = 1'b1; stall = 1'b0; end_early = 1'b0;
      step_mode = 1'b0; step = 1'b0;
      tick();
      tick();
      chk7("reset", 0, 0, 0);
      chk("reset2_phase", 32'(phase2), 32'h1);
      chk("reset2_cnt", 32'(cycle_count2), 32'h0);

      // Free run: 7-phase and 2-phase instances side by side.
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk7($sformatf("run%0d", k), k % 7, (k % 7 == 0) ? 1 : 0, k / 7);
         chk($sformatf("run2_idx%0d", k), 32'(phase_idx2), 32'(k % 2));
         chk($sformatf("run2_phase%0d", k), 32'(phase2), 32'(1) << (k % 2));
         chk($sformatf("run2_done%0d", k), 32'(cycle_done2), 32'((k % 2 == 0) ? 1 : 0));
         chk($sformatf("run2_cnt%0d", k), 32'(cycle_count2), 32'((k / 2) % 8));
      end
      // Now idx=2, count=2.
      tick();
      chk7("pre_early", 3, 0, 2);
      end_early = 1'b1;
      tick();
      chk7("early_at3", 0, 1, 3);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk7($sformatf("early_at0_%0d", k), 0, 1, 3 + k);
      end
      end_early = 1'b0;
      tick();
      chk7("early_exit", 1, 0, 6);

      tick();
      chk7("stall_enter", 2, 0, 6);
      stall = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk7($sformatf("stall%0d", k), 2, 0, 6);
      end
      stall = 1'b0;
      tick();
      chk7("stall_exit", 3, 0, 6);

      repeat (3) tick();
      chk7("to_last", 6, 0, 6);
      tick();
      chk7("wrap_ph0", 0, 1, 7);
      stall = 1'b1;
      tick();
      chk7("stall_ph0_a", 0, 0, 7);
      tick();
      chk7("stall_ph0_b", 0, 0, 7);
      stall = 1'b0;
      tick();
      chk7("stall_ph0_exit", 1, 0, 7);

      repeat (18) tick();
      chk7("pre_alive", 5, 0, 9);
      alive = 1'b0;
      tick();
      chk7("alive_drop", 0, 0, 9);
      end_early = 1'b1;
      tick();
      chk7("alive_low_early", 0, 0, 9);
      end_early = 1'b0;
      alive = 1'b1;
      tick();
      chk7("alive_back", 1, 0, 9);

      rst_n = 1'b0;
      tick();
      chk7("mid_reset", 0, 0, 0);
      rst_n = 1'b1;

`ifdef PHASE_SEQ_STEP_EN
      step_mode = 1'b1;
      tick();
      tick();
      chk7("step_wait", 0, 0, 0);
      for (int p = 1; p <= 3; p++) begin
         step = 1'b1;
         tick();
         chk7($sformatf("step_pulse%0d", p), p, 0, 0);
         step = 1'b0;
         tick();
         tick();
         chk7($sformatf("step_idle%0d", p), p, 0, 0);
      end
      stall = 1'b1;
      step = 1'b1;
      tick();
      chk7("step_stalled", 3, 0, 0);
      stall = 1'b0;
      step = 1'b0;
      tick();
      chk7("step_none", 3, 0, 0);
      step_mode = 1'b0;
      tick();
      chk7("step_off", 4, 0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
